// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } lsu_state_t;

  // Alignment only; an illegal width code is reported by is_illegal.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_H, F3_HU: bad = addr_lo[0];
      F3_W:        bad = (addr_lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic is_illegal(input logic write,
                                      input logic [2:0] funct3);
    logic bad;
    if (write) begin
      bad = (funct3 > F3_W);
    end else begin
      bad = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
              (funct3 == F3_BU) || (funct3 == F3_HU));
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load extraction with sign/zero extension and sub-word
// store merge into an existing word. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  lo,
                                          input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_BU:   r = {24'd0, b};
      F3_HU:   r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] wd,
                                        input logic [1:0]  lo,
                                        input logic [2:0]  f3);
    logic [31:0] m;
    m = old;
    case (f3)
      F3_B:    m[{lo, 3'b000} +: 8]     = wd[7:0];
      F3_H:    m[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  assign rdata  = extract(word, addr_lo, funct3);
  assign merged = merge(word, wdata, addr_lo, funct3);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts core requests, checks alignment, and drives a
// word-addressed memory with read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_dout
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE, and the response is a single-cycle pulse.
  lsu_state_t  state;
  lsu_state_t  state_next;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wdata_q;
  logic        accept;
  logic        fault;
  logic [31:0] ext_rdata;
  logic [31:0] merged;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign fault     = is_illegal(req_write, req_funct3) ||
                     is_misaligned(req_funct3, req_addr[1:0]);
  assign mem_read  = (state == READ);
  assign mem_write = (state == WRITE);

  lsu_align u_align (
    .word    (mem_dout),
    .wdata   (wdata_q),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .rdata   (ext_rdata),
    .merged  (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !fault) begin
          state_next = (req_write && (req_funct3 == F3_W)) ? WRITE : READ;
        end
      end
      READ:    state_next = write_q ? WRITE : IDLE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q         <= 1'b0;
      funct3_q        <= 3'b000;
      addr_lo_q       <= 2'b00;
      wdata_q         <= 32'd0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'd0;
      resp_misaligned <= 1'b0;
      mem_addr        <= '0;
      mem_din         <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (fault) begin
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= 32'd0;
            end else begin
              mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_write && (req_funct3 == F3_W)) begin
                mem_din <= req_wdata;
              end
            end
          end
        end
        READ: begin
          // Sub-word stores park the merged word on mem_din for the WRITE cycle.
          if (write_q) begin
            mem_din <= merged;
          end else begin
            resp_valid      <= 1'b1;
            resp_rdata      <= ext_rdata;
            resp_misaligned <= 1'b0;
          end
        end
        WRITE: begin
          resp_valid      <= 1'b1;
          resp_rdata      <= 32'd0;
          resp_misaligned <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// requests checked against a byte-level memory model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  int          n_checks;
  int          n_pass;
  logic [31:0] last_rdata;
  logic        last_mis;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_din         (mem_din),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_dout        (mem_dout)
  );

  // clock / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_din;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Driver + reference model. Called at a negedge with the DUT idle; returns
  // at the negedge of the response cycle so the next call is back-to-back.
  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic        exp_fault;
    logic [31:0] old_w, exp_rdata, new_w, v;
    int          k, idx, exp_lat, exp_rd, exp_wr;
    int          rd_c, wr_c, resp_c, n_rd, n_wr;
    logic [31:0] rd_addr, wr_addr, wr_din, got_rdata;
    logic        got_mis;

    idx   = int'(a[9:2]);
    k     = int'(a[1:0]);
    old_w = ref_mem[idx];
    if (w) exp_fault = (f3 > 3'd2);
    else   exp_fault = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!exp_fault && f3[1:0] == 2'd1 && a[0]) exp_fault = 1'b1;
    if (!exp_fault && f3[1:0] == 2'd2 && a[1:0] != 2'd0) exp_fault = 1'b1;

    exp_rdata = 32'd0;
    new_w     = old_w;
    if (!exp_fault && !w) begin
      case (f3)
        3'd0: begin v = (old_w >> (8 * k)) & 32'hFF;   if (v > 32'h7F)   v = v | 32'hFFFFFF00; exp_rdata = v; end
        3'd4: exp_rdata = (old_w >> (8 * k)) & 32'hFF;
        3'd1: begin v = (old_w >> (8 * k)) & 32'hFFFF; if (v > 32'h7FFF) v = v | 32'hFFFF0000; exp_rdata = v; end
        3'd5: exp_rdata = (old_w >> (8 * k)) & 32'hFFFF;
        default: exp_rdata = old_w;
      endcase
    end
    if (!exp_fault && w) begin
      if (f3 == 3'd2)      new_w = wd;
      else if (f3 == 3'd0) new_w = (old_w & ~(32'hFF << (8 * k)))   | ((wd & 32'hFF)   << (8 * k));
      else                 new_w = (old_w & ~(32'hFFFF << (8 * k))) | ((wd & 32'hFFFF) << (8 * k));
    end
    exp_lat = exp_fault ? 1 : ((!w || f3 == 3'd2) ? 2 : 3);
    exp_rd  = (!exp_fault && (!w || f3 != 3'd2)) ? 1 : 0;
    exp_wr  = (exp_fault || !w) ? 0 : ((f3 == 3'd2) ? 1 : 2);

    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    // Garbage while busy must be ignored.
    req_valid  = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    rd_c = 0; wr_c = 0; resp_c = 0; n_rd = 0; n_wr = 0;
    rd_addr = 32'd0; wr_addr = 32'd0; wr_din = 32'd0; got_rdata = 32'd0; got_mis = 1'b0;
    for (int c = 1; c <= 8 && resp_c == 0; c++) begin
      @(negedge clk);
      if (mem_read) begin
        n_rd++;
        if (rd_c == 0) begin rd_c = c; rd_addr = mem_addr; end
      end
      if (mem_write) begin
        n_wr++;
        if (wr_c == 0) begin wr_c = c; wr_addr = mem_addr; wr_din = mem_din; end
      end
      if (resp_valid) begin
        resp_c = c; got_rdata = resp_rdata; got_mis = resp_misaligned;
      end
    end
    req_valid = 1'b0;

    check("resp_cycle", resp_c, exp_lat);
    check("resp_rdata", got_rdata, exp_rdata);
    check("resp_misaligned", {31'd0, got_mis}, {31'd0, exp_fault});
    check("read_cycle", rd_c, exp_rd);
    check("read_count", n_rd, exp_rd != 0 ? 1 : 0);
    check("write_cycle", wr_c, exp_wr);
    check("write_count", n_wr, exp_wr != 0 ? 1 : 0);
    if (exp_rd != 0) check("read_addr", rd_addr, {a[31:2], 2'b00});
    if (exp_wr != 0) begin
      check("write_addr", wr_addr, {a[31:2], 2'b00});
      check("write_din", wr_din, new_w);
    end
    ref_mem[idx] = new_w;
    last_rdata = got_rdata;
    last_mis   = got_mis;
  endtask

  initial begin
    int bad;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h40]     = 32'h8899AABB;
    ref_mem[8'h40] = 32'h8899AABB;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_mis", {31'd0, resp_misaligned}, 32'd0);
    check("rst_mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);

    do_req(1'b0, 3'd2, 32'h100, 32'd0);
    check("lw_100", last_rdata, 32'h8899AABB);
    do_req(1'b0, 3'd0, 32'h103, 32'd0);
    check("lb_103", last_rdata, 32'hFFFFFF88);
    do_req(1'b0, 3'd4, 32'h103, 32'd0);
    check("lbu_103", last_rdata, 32'h00000088);
    do_req(1'b0, 3'd1, 32'h102, 32'd0);
    check("lh_102", last_rdata, 32'hFFFF8899);
    do_req(1'b0, 3'd5, 32'h100, 32'd0);
    check("lhu_100", last_rdata, 32'h0000AABB);
    do_req(1'b1, 3'd0, 32'h101, 32'h12345677);
    do_req(1'b0, 3'd2, 32'h100, 32'd0);
    check("lw_after_sb", last_rdata, 32'h889977BB);
    do_req(1'b0, 3'd1, 32'h101, 32'd0);
    do_req(1'b1, 3'd2, 32'h102, 32'h11111111);
    do_req(1'b0, 3'd3, 32'h100, 32'd0);
    check("fault_f3_011", {31'd0, last_mis}, 32'd1);

    // Reset during the READ cycle of SH 0x100.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h100; req_wdata = 32'h0000CAFE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_noresp", {31'd0, resp_valid}, 32'd0);
    check("rstmid_nowrite", {31'd0, mem_write}, 32'd0);
    check("rstmid_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    check("rstmid_noresp2", {30'd0, resp_valid, mem_write}, 32'd0);
    check("rstmid_mem", mem[8'h40], ref_mem[8'h40]);

    // Back-to-back LW then SW, then read the stored word back.
    do_req(1'b0, 3'd2, 32'h100, 32'd0);
    do_req(1'b1, 3'd2, 32'h104, 32'hDEADBEEF);
    do_req(1'b0, 3'd2, 32'h104, 32'd0);
    check("lw_104", last_rdata, 32'hDEADBEEF);

    for (int t = 0; t < 250; t++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      do_req(1'($urandom), f3, 32'($urandom_range(0, 1023)), $urandom);
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("final_mem_mismatches", bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface. Accepts load/store requests from the core over a valid/ready handshake and drives the word-addressed data memory port: `mem_addr`, `mem_din`, `mem_read` and `mem_write` out, `mem_dout` back. The data memory reads asynchronously, writes on the clock edge, and handles whole words only. This block therefore does:
- byte/halfword extraction with sign or zero extension;
- sub-word stores as read-modify-write;
- misalignment detection before any memory access.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width for the request and memory address.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted. High exactly when the state is IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101;
  - stores: SB=000, SH=001, SW=010.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse. There is no backpressure.
- resp_rdata  out  32  load result. It is 0 for stores and for faults.
- resp_misaligned  out  1  fault flag, qualified by resp_valid.
- mem_addr  out  ADDR_WIDTH  word-aligned address, `{req_addr[ADDR_WIDTH-1:2], 2'b00}`.
- mem_din  out  32  write data.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_dout  in  32  memory read data, valid in the same cycle as mem_read.

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. At that edge it latches write, funct3, addr and wdata.
- States: IDLE, READ, WRITE.
- Transitions from IDLE on accept:
  - Fault → IDLE, with resp_valid=1 and resp_misaligned=1 in the next cycle. No memory strobe is ever raised.
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- Faults are:
  - a halfword with addr[0]=1;
  - a word with addr[1:0]≠0;
  - an illegal funct3: loads other than the five listed, stores ≥ 011.
- READ state:
  - mem_read=1. mem_addr is the aligned address.
  - mem_dout is captured at the end of the cycle.
  - Load → IDLE, with resp_valid=1 and resp_rdata holding the extracted value.
  - SB/SH → WRITE, holding the merged word.
- WRITE state:
  - mem_write=1, mem_din is the full word (SW) or the merged word (SB/SH).
  - → IDLE, with resp_valid=1 and resp_rdata=0.
- Byte lanes are little-endian. Byte k is bits [8k+7:8k], with k = addr[1:0].
  - A halfword uses lanes k and k+1, k ∈ {0,2}.
- Extraction:
  - LB/LH sign-extend from bit 7/15 of the selected lane(s).
  - LBU/LHU zero-extend.
- Merge: the old word with lane(s) k (or k, k+1) replaced by req_wdata[7:0] (or [15:0]). All other lanes are unchanged.
- In IDLE, mem_read = mem_write = 0. mem_addr and mem_din hold their last values, or 0 after reset.

## Timing
Accept edge = end of cycle 0.
- Load: mem_read in cycle 1; resp_valid in cycle 2. Latency 2.
- SW: mem_write in cycle 1; resp_valid in cycle 2.
- SB/SH: mem_read in cycle 1, mem_write in cycle 2; resp_valid in cycle 3.
- Fault: resp_valid in cycle 1.
- A new request can be accepted in the same cycle as the previous response (back-to-back).
- resp_rdata and resp_misaligned hold their values until the next response. A pulse must be sampled in its own cycle.
- Reset values: req_ready=1 from the first cycle after reset; resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
- Reset mid-operation aborts to IDLE. No further strobe is raised and no response is issued. If reset coincides with WRITE, the memory write on that edge still occurs, because the strobe is already driven. If reset is asserted in READ, no write ever follows.
- req_* inputs are ignored while not IDLE.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum {IDLE, READ, WRITE};
  - a helper function `is_misaligned(funct3, addr_lo)`.
- Sub-module `lsu_align`, purely combinational, with two functions:
  - load extraction (word, addr[1:0], funct3 → rdata);
  - store merge (old word, wdata, addr[1:0], funct3 → new word).
- The top level holds the FSM and the request/response registers.

## Test plan
Preload word 0x100 = 0x8899AABB.
- LW 0x100:
  - mem_read=1 with mem_addr=0x100 in cycle 1 only;
  - resp_valid in cycle 2 with rdata=0x8899AABB.
- Sub-word loads:
  - LB 0x103 → 0xFFFFFF88;
  - LBU 0x103 → 0x00000088;
  - LH 0x102 → 0xFFFF8899;
  - LHU 0x100 → 0x0000AABB.
- SB 0x101, wdata 0x12345677:
  - mem_read in cycle 1;
  - mem_write in cycle 2 with din=0x889977BB;
  - resp in cycle 3;
  - a following LW 0x100 returns 0x889977BB.
- Faults: LH 0x101, SW 0x102, and a load with funct3=011 each give resp_misaligned=1 in cycle 1. mem_read and mem_write are never asserted.
- Reset asserted during the READ cycle of SH 0x100: memory stays unchanged, there is no resp_valid, and req_ready=1 in the next cycle.
- Back-to-back: req_valid held high with LW 0x100 then SW 0x104 = 0xDEADBEEF. The second request is accepted in cycle 2, the resp of the first appears in cycle 2, and the SW response comes in cycle 4.
